fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch stage for the single-cycle datapath's successor pipeline. Owns the program counter, issues sequential word fetches to instruction memory over a request/acknowledge handshake, buffers returned instructions with their PC in a small FIFO, and hands them to decode over a valid/ready handshake. A branch redirect flushes the buffer, restarts fetch at the target, and discards any in-flight response.

## Interface

Parameters:
- ADDR_W, 32, PC and memory address width
- INSTR_W, 32, instruction width
- DEPTH, 4, prefetch FIFO entries (power of two, ≥2)
- RESET_PC, 0, PC value loaded on reset

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- IMEM_REQ  out  1  fetch request
- IMEM_ADDR  out  ADDR_W  fetch address, word aligned
- IMEM_ACK  in  1  request accepted; IMEM_DATA valid this cycle
- IMEM_DATA  in  INSTR_W  fetched instruction
- BR_TAKEN  in  1  redirect strobe from execute
- BR_TARGET  in  ADDR_W  redirect address; bits [1:0] ignored, forced to 0
- INSTR_VALID  out  1  FIFO head valid
- INSTR_READY  in  1  decode accepts head
- INSTR  out  INSTR_W  head instruction
- INSTR_PC  out  ADDR_W  head instruction address
- INSTR_PCPLUS4  out  ADDR_W  INSTR_PC + 4, modulo 2^ADDR_W

## Operation

- Registers: PC (next fetch address), REQ_ADDR (address of outstanding request), FIFO of {PC, instruction}, count 0..DEPTH, state.
- States: RUN, DROP.
- RUN: IMEM_REQ = (count < DEPTH); IMEM_ADDR = PC. Once REQ asserted it stays asserted with stable address until IMEM_ACK (count cannot grow while waiting, so this holds).
- RUN, REQ & ACK & !BR_TAKEN: push {PC, IMEM_DATA}; PC ← PC + 4 (wraps at 2^ADDR_W).
- RUN, BR_TAKEN: flush FIFO (count ← 0); PC ← {BR_TARGET[ADDR_W-1:2], 2'b00}. If REQ & !ACK: REQ_ADDR ← PC, go DROP. Otherwise (no request, or ACK same cycle) response discarded, stay RUN.
- DROP: IMEM_REQ = 1, IMEM_ADDR = REQ_ADDR. On ACK: discard data, go RUN. BR_TAKEN in DROP: flush (already empty), PC ← new target, stay/leave DROP per ACK as normal.
- Decode side: INSTR_VALID = (count ≠ 0); pop when INSTR_VALID & INSTR_READY.
- Same-cycle push and pop: count unchanged, both take effect.
- Redirect priority: BR_TAKEN beats push and pop; a handshake occurring in the redirect cycle is considered transferred by decode, FIFO is still flushed.
- No push ever occurs at count == DEPTH (REQ deasserted).

## Timing

- Reset (RST_N low, asynchronous): PC = RESET_PC, state RUN, count 0, IMEM_REQ 0, IMEM_ADDR = RESET_PC, INSTR_VALID 0, INSTR/INSTR_PC/INSTR_PCPLUS4 = 0. REQ rises combinationally in the first cycle after RST_N deasserts.
- Reset mid-request: request abandoned; memory must tolerate REQ dropping without ACK.
- Fetch-to-decode latency: instruction acked in cycle N is INSTR_VALID in cycle N+1.
- Sustained throughput: one instruction per cycle with single-cycle ACK and READY held high.
- Redirect in cycle N: INSTR_VALID low in N+1; first fetch of target issued in N+1 (RUN) or the cycle after the dropped ACK (DROP).
- IMEM_ACK without IMEM_REQ is ignored.

## Structure

- Shared package fetch_pkg: state enum (RUN, DROP), fetch-entry struct {pc, instr}, word-increment constant 4.
- Sub-module fetch_fifo: parametrised synchronous FIFO (width, DEPTH), push/pop/flush, count, head output; async active-low reset. Top handles PC, FSM, and handshakes.

## Test plan

- Reset, ACK tied high, READY high, RESET_PC=0x100 -> INSTR_PC sequence 0x100, 0x104, 0x108 on consecutive cycles, INSTR_PCPLUS4 = INSTR_PC+4.
- READY low, ACK high, DEPTH=4 -> exactly 4 pushes, IMEM_REQ low at count 4; READY pulse for one cycle -> one pop, one further fetch.
- ACK delayed 3 cycles -> IMEM_ADDR stable, REQ held; BR_TAKEN target 0x2003 while waiting -> DROP, response discarded, next fetch address 0x2000, first valid INSTR_PC 0x2000.
- BR_TAKEN coincident with ACK and with FIFO holding 3 entries -> FIFO empty next cycle, acked data never appears, fetch restarts at target.
- PC at 0xFFFFFFFC with ADDR_W=32 -> next fetch address 0x00000000, INSTR_PCPLUS4 of last entry 0x00000000.
- RST_N asserted mid-burst with FIFO non-empty -> INSTR_VALID and IMEM_REQ low immediately, PC = RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   fetch_state_e : fetch FSM states (RUN fetches sequentially, DROP waits out
//                   a response that a redirect has made stale)
//   fetch_entry_t : layout of one prefetch-buffer entry at the default 32/32
//                   widths; the top packs {pc, instr} in this same order
//   WORD_INC      : PC step between sequential fetches (one 32-bit word)
package fetch_pkg;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_DROP = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int unsigned WORD_INC = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with single-cycle flush.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   push, push_data : write one entry (caller never pushes when full)
//   pop             : drop the head entry (caller never pops when empty)
//   flush           : empty the FIFO; overrides push and pop in the same cycle
//   count           : number of valid entries, 0..DEPTH
//   head            : oldest entry, forced to zero while empty
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked until an entry is written.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues sequential word fetches over a
// req/ack handshake, buffers {pc, instr} in a prefetch FIFO and presents the
// head to decode over valid/ready. A taken branch flushes the buffer and
// restarts fetch at the (word-aligned) target; a response still owed for a
// request issued before the redirect is absorbed in DROP.
// Ports:
//   clk, rst_n                        : clock, asynchronous active-low reset
//   imem_req, imem_addr               : fetch request and word address
//   imem_ack, imem_data               : request accepted, data valid same cycle
//   br_taken, br_target               : redirect strobe and target
//   instr_valid, instr_ready          : decode handshake
//   instr, instr_pc, instr_pcplus4    : head instruction, its address, address+4
//
// state | meaning
// RUN   | fetching at pc whenever the buffer has room
// DROP  | replaying the stale request at req_addr until its ack, data dropped
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               ADDR_W   = 32,
    parameter int               INSTR_W  = 32,
    parameter int               DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [ADDR_W-1:0]  instr_pcplus4
);

    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = ADDR_W + INSTR_W;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] INC      = ADDR_W'(WORD_INC);
    localparam logic [ADDR_W-1:0] ALIGN    = ~ADDR_W'(3);

    fetch_state_e        state;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   req_addr;
    logic [ADDR_W-1:0]   target;
    logic [CNT_W-1:0]    count;
    logic [ENTRY_W-1:0]  head;
    logic                push;
    logic                pop;

    assign target = br_target & ALIGN;

    // Gating with rst_n drops the request the moment reset asserts and lets
    // it rise in the first cycle after release without waiting for an edge.
    assign imem_req  = rst_n && ((state == ST_DROP) || (count != FULL_CNT));
    assign imem_addr = (state == ST_DROP) ? req_addr : pc;

    assign push = (state == ST_RUN) && imem_req && imem_ack && !br_taken;
    assign pop  = instr_valid && instr_ready && !br_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            case (state)
                ST_RUN: begin
                    if (br_taken) begin
                        pc <= target;
                        // The memory still owes a response for the old pc.
                        if (imem_req && !imem_ack) begin
                            req_addr <= pc;
                            state    <= ST_DROP;
                        end
                    end else if (push) begin
                        pc <= pc + INC;
                    end
                end
                ST_DROP: begin
                    if (br_taken) pc <= target;
                    if (imem_ack) state <= ST_RUN;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({pc, imem_data}),
        .pop       (pop),
        .flush     (br_taken),
        .count     (count),
        .head      (head)
    );

    assign instr_valid   = (count != '0);
    assign instr_pc      = head[ENTRY_W-1:INSTR_W];
    assign instr         = head[INSTR_W-1:0];
    assign instr_pcplus4 = instr_valid ? instr_pc + INC : '0;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        br_taken;
    logic [31:0] br_target;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pcplus4;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .DEPTH    (4),
        .RESET_PC (32'h0000_0100)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_data     (imem_data),
        .br_taken      (br_taken),
        .br_target     (br_target),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_pcplus4 (instr_pcplus4)
    );

    // Instruction memory model: each word's contents derive from its address.
    function automatic logic [31:0] memw(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    always_comb imem_data = memw(imem_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ack, input logic ready);
        rst_n       = 1'b0;
        br_taken    = 1'b0;
        br_target   = '0;
        imem_ack    = ack;
        instr_ready = ready;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        imem_ack    = 1'b1;
        instr_ready = 1'b1;
        br_taken    = 1'b0;
        br_target   = '0;

        // Reset state, then streaming with ack and ready held high.
        tick();
        chk("rst_req",    {31'd0, imem_req},    32'd0);
        chk("rst_addr",   imem_addr,            32'h100);
        chk("rst_valid",  {31'd0, instr_valid}, 32'd0);
        chk("rst_instr",  instr,                32'd0);
        chk("rst_pc",     instr_pc,             32'd0);
        chk("rst_pc4",    instr_pcplus4,        32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_req",    {31'd0, imem_req},    32'd1);
        chk("rel_addr",   imem_addr,            32'h100);
        tick();
        chk("s1_valid",   {31'd0, instr_valid}, 32'd1);
        chk("s1_pc0",     instr_pc,             32'h100);
        chk("s1_pc4_0",   instr_pcplus4,        32'h104);
        chk("s1_instr0",  instr,                memw(32'h100));
        chk("s1_addr",    imem_addr,            32'h104);
        tick();
        chk("s1_pc1",     instr_pc,             32'h104);
        tick();
        chk("s1_pc2",     instr_pc,             32'h108);
        chk("s1_pc4_2",   instr_pcplus4,        32'h10C);

        // Decode stalled: fill to DEPTH, then a single-cycle ready pulse.
        do_reset(1'b1, 1'b0);
        tick(); tick(); tick();
        chk("s2_req3",    {31'd0, imem_req},    32'd1);
        tick();
        chk("s2_full_req", {31'd0, imem_req},   32'd0);
        chk("s2_full_addr", imem_addr,          32'h110);
        chk("s2_head",    instr_pc,             32'h100);
        tick();
        chk("s2_hold_req", {31'd0, imem_req},   32'd0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        #1;
        chk("s2_pop_req", {31'd0, imem_req},    32'd1);
        chk("s2_pop_head", instr_pc,            32'h104);
        chk("s2_pop_addr", imem_addr,           32'h110);
        tick();
        chk("s2_refill_req", {31'd0, imem_req}, 32'd0);
        chk("s2_refill_addr", imem_addr,        32'h114);
        chk("s2_refill_head", instr_pc,         32'h104);

        // Slow memory, redirect while a request is outstanding.
        do_reset(1'b0, 1'b1);
        chk("s3_req",     {31'd0, imem_req},    32'd1);
        tick();
        chk("s3_w1_addr", imem_addr,            32'h100);
        tick();
        tick();
        chk("s3_w3_req",  {31'd0, imem_req},    32'd1);
        chk("s3_w3_addr", imem_addr,            32'h100);
        br_taken  = 1'b1;
        br_target = 32'h2003;
        tick();
        br_taken = 1'b0;
        #1;
        chk("s3_drop_req",  {31'd0, imem_req},  32'd1);
        chk("s3_drop_addr", imem_addr,          32'h100);
        chk("s3_drop_valid", {31'd0, instr_valid}, 32'd0);
        imem_ack = 1'b1;
        tick();
        chk("s3_disc_valid", {31'd0, instr_valid}, 32'd0);
        chk("s3_tgt_addr",  imem_addr,          32'h2000);
        chk("s3_tgt_req",   {31'd0, imem_req},  32'd1);
        tick();
        chk("s3_first_valid", {31'd0, instr_valid}, 32'd1);
        chk("s3_first_pc",  instr_pc,           32'h2000);
        chk("s3_first_instr", instr,            memw(32'h2000));

        // Redirect coincident with ack while three entries are buffered.
        do_reset(1'b1, 1'b0);
        tick(); tick(); tick();
        chk("s4_pre_valid", {31'd0, instr_valid}, 32'd1);
        chk("s4_pre_addr",  imem_addr,          32'h10C);
        br_taken  = 1'b1;
        br_target = 32'h3000;
        tick();
        br_taken = 1'b0;
        #1;
        chk("s4_flush_valid", {31'd0, instr_valid}, 32'd0);
        chk("s4_tgt_addr",  imem_addr,          32'h3000);
        chk("s4_tgt_req",   {31'd0, imem_req},  32'd1);
        tick();
        chk("s4_head_pc",   instr_pc,           32'h3000);
        chk("s4_head_instr", instr,             memw(32'h3000));
        tick();
        chk("s4_head_keep", instr_pc,           32'h3000);

        // PC wrap at the top of the address space.
        do_reset(1'b1, 1'b1);
        br_taken  = 1'b1;
        br_target = 32'hFFFF_FFFF;
        tick();
        br_taken = 1'b0;
        #1;
        chk("s5_top_addr",  imem_addr,          32'hFFFF_FFFC);
        chk("s5_top_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        chk("s5_top_pc",    instr_pc,           32'hFFFF_FFFC);
        chk("s5_top_pc4",   instr_pcplus4,      32'h0);
        chk("s5_wrap_addr", imem_addr,          32'h0);
        tick();
        chk("s5_zero_pc",   instr_pc,           32'h0);
        chk("s5_zero_pc4",  instr_pcplus4,      32'h4);

        // Asynchronous reset in the middle of a burst.
        chk("s6_pre_valid", {31'd0, instr_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("s6_valid",     {31'd0, instr_valid}, 32'd0);
        chk("s6_req",       {31'd0, imem_req},  32'd0);
        chk("s6_addr",      imem_addr,          32'h100);
        chk("s6_pc",        instr_pc,           32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("s6_rel_addr",  imem_addr,          32'h100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
